// File: rtl/rectangle_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rectangle_pkg
// Description : Shared definitions for the masked RECTANGLE S-box sequencer.
//               Holds the sequencer FSM encoding, the state geometry and the
//               column extract/insert helpers. The column nibble is
//               {row3[j], row2[j], row1[j], row0[j]}, where row r of a 64-bit
//               state is bits [16r+15:16r]. Also holds the plain RECTANGLE
//               S-box table, which is a reference table for benches and is
//               not used by the synthesizable datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package rectangle_pkg;

    localparam int NCOL = 16;
    localparam int NROW = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] C_RECT_SBOX [16] = '{
        4'h6, 4'h5, 4'hC, 4'hA, 4'h1, 4'hE, 4'h7, 4'h9,
        4'hB, 4'h0, 4'h3, 4'hD, 4'h8, 4'hF, 4'h4, 4'h2
    };

    // Gather bit j of each row into one nibble, row 0 in the LSB.
    function automatic logic [3:0] col_extract(input logic [63:0] s,
                                               input logic [3:0]  j);
        logic [3:0] nib;
        nib = 4'd0;
        for (int r = 0; r < NROW; r++) begin
            nib[r] = s[NCOL*r + int'(j)];
        end
        return nib;
    endfunction

    // Scatter a nibble back into bit j of each row; other bits untouched.
    function automatic logic [63:0] col_insert(input logic [63:0] s,
                                               input logic [3:0]  j,
                                               input logic [3:0]  nib);
        logic [63:0] res;
        res = s;
        for (int r = 0; r < NROW; r++) begin
            res[NCOL*r + int'(j)] = nib[r];
        end
        return res;
    endfunction

endpackage : rectangle_pkg
`default_nettype wire

// File: rtl/rectangle_share_colreg.sv
`default_nettype none
// ============================================================================
// Module      : rectangle_share_colreg
// Description : One 64-bit share register with an indexed column read port
//               (combinational) and an indexed column write port. A bulk
//               load takes priority over a column write.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_load          - load i_load_data into the whole register
//               i_rd_idx        - column index for o_rd_nib
//               i_wr_en         - write i_wr_nib into column i_wr_idx
//               o_q             - full register contents
// Revision    : 1.0 - initial release
// ============================================================================
module rectangle_share_colreg
    import rectangle_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic [63:0] i_load_data,
    input  logic [3:0]  i_rd_idx,
    output logic [3:0]  o_rd_nib,
    input  logic        i_wr_en,
    input  logic [3:0]  i_wr_idx,
    input  logic [3:0]  i_wr_nib,
    output logic [63:0] o_q
);

    logic [63:0] r_share;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_share <= 64'd0;
        end else if (i_load) begin
            r_share <= i_load_data;
        end else if (i_wr_en) begin
            r_share <= col_insert(r_share, i_wr_idx, i_wr_nib);
        end
    end

    assign o_rd_nib = col_extract(r_share, i_rd_idx);
    assign o_q      = r_share;

endmodule : rectangle_share_colreg
`default_nettype wire

// File: rtl/rectangle_sbox_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rectangle_sbox_sequencer
// Description : Streams the 16 columns of a 3-share masked RECTANGLE state
//               through one external fixed-latency masked S-box, one column
//               per cycle in which fresh randomness is available, and writes
//               the returned shares back in place.
// Ports       : clk, rst                 - clock, synchronous active-high reset
//               in_valid/in_ready, s1..s3 - input state shares
//               rnd_valid/rnd_ready, rnd - per-column fresh randomness
//               sb_x1..sb_x3, sb_rnd     - column shares to the S-box
//               sb_y1..sb_y3             - S-box output shares (SB_LAT later)
//               out_valid/out_ready, t1..t3 - substituted state shares
// Parameters  : SB_LAT (1..8) S-box latency, RND_W random bits per column
// Revision    : 1.0 - initial release
// ============================================================================
module rectangle_sbox_sequencer
    import rectangle_pkg::*;
#(
    parameter int SB_LAT = 2,
    parameter int RND_W  = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [63:0]      s1,
    input  logic [63:0]      s2,
    input  logic [63:0]      s3,
    input  logic             rnd_valid,
    input  logic [RND_W-1:0] rnd,
    output logic             rnd_ready,
    output logic [3:0]       sb_x1,
    output logic [3:0]       sb_x2,
    output logic [3:0]       sb_x3,
    output logic [RND_W-1:0] sb_rnd,
    input  logic [3:0]       sb_y1,
    input  logic [3:0]       sb_y2,
    input  logic [3:0]       sb_y3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      t1,
    output logic [63:0]      t2,
    output logic [63:0]      t3
);

    state_t            r_state;
    logic [3:0]        r_issue_cnt;
    logic [3:0]        r_retire_cnt;
    // Bit k is set when the column issued k+1 cycles ago is a real one;
    // the MSB therefore flags that sb_y* carries a column to capture.
    logic [SB_LAT-1:0] r_vpipe;

    logic              w_load;
    logic              w_issue;
    logic              w_retire;

    logic [63:0]       w_s_in   [3];
    logic [3:0]        w_y      [3];
    logic [3:0]        w_rd_nib [3];
    logic [63:0]       w_q      [3];

    assign w_load   = (r_state == ST_IDLE) && in_valid;
    assign w_issue  = (r_state == ST_ISSUE) && rnd_valid;
    assign w_retire = r_vpipe[SB_LAT-1];

    assign w_s_in[0] = s1;
    assign w_s_in[1] = s2;
    assign w_s_in[2] = s3;
    assign w_y[0]    = sb_y1;
    assign w_y[1]    = sb_y2;
    assign w_y[2]    = sb_y3;

    // Each share lives in its own register; shares are never combined.
    // Writing column retire_cnt while reading column issue_cnt is safe
    // because a column is always retired after it has been issued.
    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_share
            rectangle_share_colreg u_colreg (
                .clk         (clk),
                .rst         (rst),
                .i_load      (w_load),
                .i_load_data (w_s_in[g]),
                .i_rd_idx    (r_issue_cnt),
                .o_rd_nib    (w_rd_nib[g]),
                .i_wr_en     (w_retire),
                .i_wr_idx    (r_retire_cnt),
                .i_wr_nib    (w_y[g]),
                .o_q         (w_q[g])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_issue_cnt  <= 4'd0;
            r_retire_cnt <= 4'd0;
            r_vpipe      <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < SB_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end

            // The S-box never stalls, so capture happens in whatever state
            // the result arrives in.
            if (w_retire) begin
                r_retire_cnt <= r_retire_cnt + 4'd1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_issue_cnt  <= 4'd0;
                        r_retire_cnt <= 4'd0;
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (rnd_valid) begin
                        r_issue_cnt <= r_issue_cnt + 4'd1;
                        if (r_issue_cnt == 4'(NCOL - 1)) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_retire && (r_retire_cnt == 4'(NCOL - 1))) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign rnd_ready = (r_state == ST_ISSUE);
    assign out_valid = (r_state == ST_DONE);

    // S-box inputs are forced to zero except in an issuing cycle so that
    // masked data and randomness never linger on the S-box ports.
    assign sb_x1  = w_issue ? w_rd_nib[0] : 4'd0;
    assign sb_x2  = w_issue ? w_rd_nib[1] : 4'd0;
    assign sb_x3  = w_issue ? w_rd_nib[2] : 4'd0;
    assign sb_rnd = w_issue ? rnd : '0;

    // Partial results are only exposed once the whole layer is complete.
    assign t1 = out_valid ? w_q[0] : 64'd0;
    assign t2 = out_valid ? w_q[1] : 64'd0;
    assign t3 = out_valid ? w_q[2] : 64'd0;

endmodule : rectangle_sbox_sequencer
`default_nettype wire
